// File: rtl/trap_ctrl.sv
// Trap entry / MRET return sequencer for the RV32IM single-cycle core.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt dispatch when mtvec mode is 01.
module trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        exc_fetch_misalign,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_load_misalign,
    input  logic        exc_store_misalign,
    input  logic        is_mret,
    input  logic        irq_ext,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        kill,
    output logic        stall,
    output logic        retire,
    output logic        trap_enter,
    output logic        trap_exit,
    output logic [31:0] exception_code,
    output logic [31:0] current_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_RET  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        irq_q;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        irq_take;
    logic        cause_vld;
    logic [31:0] cause_code;
    logic [31:0] vec_base;
    logic [31:0] trap_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            irq_q   <= 1'b0;
            cause_q <= 32'd0;
            epc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_ext;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // Interrupt outranks every synchronous exception; lower entries only matter if nothing above fires.
    always_comb begin
        irq_take   = irq_q & mstatus_mie & instr_valid;
        cause_vld  = 1'b1;
        cause_code = 32'd0;
        if (irq_take) begin
            cause_code = 32'h8000_000B;
        end else if (instr_valid && exc_fetch_misalign) begin
            cause_code = 32'd0;
        end else if (instr_valid && exc_illegal) begin
            cause_code = 32'd2;
        end else if (instr_valid && exc_ebreak) begin
            cause_code = 32'd3;
        end else if (instr_valid && exc_ecall) begin
            cause_code = 32'd11;
        end else if (instr_valid && exc_load_misalign) begin
            cause_code = 32'd4;
        end else if (instr_valid && exc_store_misalign) begin
            cause_code = 32'd6;
        end else begin
            cause_vld = 1'b0;
        end
    end

    assign vec_base = {mtvec_in[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_vec = vec_base;
        if (mtvec_in[1:0] == 2'b01 && cause_q[31]) begin
            trap_vec = vec_base + {25'd0, cause_q[4:0], 2'b00};
        end
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_in[1:0];
    assign trap_vec          = vec_base;
`endif

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        kill           = 1'b0;
        stall          = 1'b0;
        retire         = 1'b0;
        trap_enter     = 1'b0;
        trap_exit      = 1'b0;
        exception_code = 32'd0;
        current_pc     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = RESET_PC;

        case (state_q)
            S_RUN: begin
                if (cause_vld) begin
                    kill    = 1'b1;
                    cause_d = cause_code;
                    epc_d   = pc;
                    state_d = S_TRAP;
                end else if (instr_valid && is_mret) begin
                    kill    = 1'b1;
                    state_d = S_RET;
                end else begin
                    retire = instr_valid;
                end
            end
            S_TRAP: begin
                trap_enter     = 1'b1;
                exception_code = cause_q;
                current_pc     = epc_q;
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = trap_vec;
                state_d        = S_RUN;
            end
            S_RET: begin
                trap_exit      = 1'b1;
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mepc_in;
                state_d        = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Reset forces quiet outputs so an in-flight trap/return never emits its pulse.
        if (reset) begin
            kill           = 1'b0;
            stall          = 1'b0;
            retire         = 1'b0;
            trap_enter     = 1'b0;
            trap_exit      = 1'b0;
            exception_code = 32'd0;
            current_pc     = 32'd0;
            redirect_valid = 1'b0;
            redirect_pc    = RESET_PC;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: each step queues the expected output vector for that cycle.
module tb_trap_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] IRQ_VEC = 32'h0000_022C;
`else
    localparam logic [31:0] IRQ_VEC = 32'h0000_0200;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exc_fetch_misalign, exc_illegal, exc_ebreak, exc_ecall;
    logic        exc_load_misalign, exc_store_misalign;
    logic        is_mret, irq_ext, mstatus_mie;
    logic [31:0] mtvec_in, mepc_in;
    logic        kill, stall, retire, trap_enter, trap_exit, redirect_valid;
    logic [31:0] exception_code, current_pc, redirect_pc;

    trap_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .pc(pc),
        .exc_fetch_misalign(exc_fetch_misalign), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_load_misalign(exc_load_misalign), .exc_store_misalign(exc_store_misalign),
        .is_mret(is_mret), .irq_ext(irq_ext), .mstatus_mie(mstatus_mie),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .kill(kill), .stall(stall), .retire(retire),
        .trap_enter(trap_enter), .trap_exit(trap_exit),
        .exception_code(exception_code), .current_pc(current_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // exc bits: [5] fetch, [4] illegal, [3] ebreak, [2] ecall, [1] load, [0] store
    typedef struct {
        logic         rst;
        logic         iv;
        logic [31:0]  pc;
        logic [5:0]   exc;
        logic         mret;
        logic         irq;
        logic         mie;
        logic [31:0]  mtvec;
        logic [31:0]  mepc;
        logic [101:0] exp;
    } step_t;

    logic [101:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;

    function automatic logic [101:0] ev(logic k, logic s, logic r, logic te, logic tx,
                                        logic [31:0] code, logic [31:0] cpc,
                                        logic rv, logic [31:0] rpc);
        return {k, s, r, te, tx, code, cpc, rv, rpc};
    endfunction

    function automatic logic [101:0] e_idle();
        return ev(0, 0, 0, 0, 0, 32'd0, 32'd0, 0, RST_PC);
    endfunction
    function automatic logic [101:0] e_kill();
        return ev(1, 0, 0, 0, 0, 32'd0, 32'd0, 0, RST_PC);
    endfunction
    function automatic logic [101:0] e_retire();
        return ev(0, 0, 1, 0, 0, 32'd0, 32'd0, 0, RST_PC);
    endfunction
    function automatic logic [101:0] e_trap(logic [31:0] code, logic [31:0] cpc, logic [31:0] vec);
        return ev(0, 1, 0, 1, 0, code, cpc, 1, vec);
    endfunction
    function automatic logic [101:0] e_ret(logic [31:0] tgt);
        return ev(0, 1, 0, 0, 1, 32'd0, 32'd0, 1, tgt);
    endfunction

    function automatic step_t mk(logic rst, logic iv, logic [31:0] p, logic [5:0] exc,
                                 logic mret, logic irq, logic mie,
                                 logic [31:0] mtv, logic [31:0] mep, logic [101:0] e);
        step_t s;
        s.rst = rst; s.iv = iv; s.pc = p; s.exc = exc; s.mret = mret;
        s.irq = irq; s.mie = mie; s.mtvec = mtv; s.mepc = mep; s.exp = e;
        return s;
    endfunction

    function automatic logic [101:0] observed();
        return {kill, stall, retire, trap_enter, trap_exit, exception_code, current_pc,
                redirect_valid, redirect_pc};
    endfunction

    task automatic apply(input step_t s);
        @(negedge clk);
        reset              = s.rst;
        instr_valid        = s.iv;
        pc                 = s.pc;
        exc_fetch_misalign = s.exc[5];
        exc_illegal        = s.exc[4];
        exc_ebreak         = s.exc[3];
        exc_ecall          = s.exc[2];
        exc_load_misalign  = s.exc[1];
        exc_store_misalign = s.exc[0];
        is_mret            = s.mret;
        irq_ext            = s.irq;
        mstatus_mie        = s.mie;
        mtvec_in           = s.mtvec;
        mepc_in            = s.mepc;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t        st[$];
        logic [101:0] want, got;
        st.push_back(mk(1, 1, 32'h10, 6'b010000, 0, 1, 1, 32'h200, 32'h0, e_idle()));
        st.push_back(mk(1, 1, 32'h10, 6'b000000, 1, 1, 1, 32'h200, 32'h0, e_idle()));
        st.push_back(mk(0, 0, 32'h10, 6'b000000, 0, 0, 0, 32'h200, 32'h0, e_idle()));
        st.push_back(mk(0, 0, 32'h10, 6'b000100, 0, 0, 0, 32'h200, 32'h0, e_idle()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_illegal();
        step_t        st[$];
        logic [101:0] want, got;
        st.push_back(mk(0, 1, 32'h100, 6'b010000, 0, 0, 0, 32'h200, 32'h0, e_kill()));
        st.push_back(mk(0, 0, 32'h100, 6'b000000, 0, 0, 0, 32'h200, 32'h0, e_trap(32'd2, 32'h100, 32'h200)));
        st.push_back(mk(0, 1, 32'h200, 6'b000000, 0, 0, 0, 32'h200, 32'h0, e_retire()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL illegal step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_mret();
        step_t        st[$];
        logic [101:0] want, got;
        st.push_back(mk(0, 1, 32'h204, 6'b000000, 1, 0, 0, 32'h200, 32'h999, e_kill()));
        st.push_back(mk(0, 0, 32'h204, 6'b000000, 0, 0, 0, 32'h200, 32'h104, e_ret(32'h104)));
        st.push_back(mk(0, 0, 32'h104, 6'b000000, 0, 0, 0, 32'h200, 32'h104, e_idle()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mret step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_irq_priority();
        step_t        st[$];
        logic [101:0] want, got;
        st.push_back(mk(0, 1, 32'h3C, 6'b000000, 0, 1, 1, 32'h201, 32'h0, e_retire()));
        st.push_back(mk(0, 1, 32'h40, 6'b000100, 0, 1, 1, 32'h201, 32'h0, e_kill()));
        st.push_back(mk(0, 0, 32'h40, 6'b000000, 0, 0, 1, 32'h201, 32'h0, e_trap(32'h8000_000B, 32'h40, IRQ_VEC)));
        st.push_back(mk(0, 1, 32'h44, 6'b000000, 0, 0, 1, 32'h201, 32'h0, e_retire()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL irq_priority step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_irq_masked();
        step_t        st[$];
        logic [101:0] want, got;
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k % 3) != 0;
            st.push_back(mk(0, v, 32'h500 + 32'(4 * k), 6'b000000, 0, 1, 0, 32'h200, 32'h0,
                            v ? e_retire() : e_idle()));
        end
        st.push_back(mk(0, 0, 32'h600, 6'b000000, 0, 0, 0, 32'h200, 32'h0, e_idle()));
        st.push_back(mk(0, 0, 32'h600, 6'b000000, 0, 0, 0, 32'h200, 32'h0, e_idle()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL irq_masked step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_exc_priority();
        step_t        st[$];
        logic [101:0] want, got;
        logic [5:0]   flags[6] = '{6'b111000, 6'b011000, 6'b001100, 6'b000100, 6'b000011, 6'b000001};
        logic         mrets[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0]  codes[6] = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
        for (int k = 0; k < 6; k++) begin
            logic [31:0] p;
            p = 32'h300 + 32'(16 * k);
            st.push_back(mk(0, 1, p, flags[k], mrets[k], 0, 1, 32'h201, 32'h0, e_kill()));
            st.push_back(mk(0, 0, p, 6'b000000, 0, 0, 1, 32'h201, 32'h0, e_trap(codes[k], p, 32'h200)));
        end
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL exc_priority step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_abort();
        step_t        st[$];
        logic [101:0] want, got;
        st.push_back(mk(0, 1, 32'h700, 6'b010000, 0, 0, 0, 32'h200, 32'h800, e_kill()));
        st.push_back(mk(1, 0, 32'h700, 6'b000000, 0, 0, 0, 32'h200, 32'h800, e_idle()));
        st.push_back(mk(0, 0, 32'h700, 6'b000000, 0, 0, 0, 32'h200, 32'h800, e_idle()));
        st.push_back(mk(0, 1, 32'h704, 6'b000000, 1, 0, 0, 32'h200, 32'h800, e_kill()));
        st.push_back(mk(1, 0, 32'h704, 6'b000000, 0, 0, 0, 32'h200, 32'h800, e_idle()));
        st.push_back(mk(0, 0, 32'h704, 6'b000000, 0, 0, 0, 32'h200, 32'h800, e_idle()));
        st.push_back(mk(0, 1, 32'h708, 6'b000000, 0, 0, 0, 32'h200, 32'h800, e_retire()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_abort step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t        st[$];
        logic [101:0] want, got;
        st.push_back(mk(0, 1, 32'h900, 6'b001000, 0, 0, 0, 32'h400, 32'hA00, e_kill()));
        st.push_back(mk(0, 1, 32'h904, 6'b000100, 1, 0, 0, 32'h400, 32'hA00, e_trap(32'd3, 32'h900, 32'h400)));
        st.push_back(mk(0, 1, 32'h400, 6'b000001, 0, 0, 0, 32'h400, 32'hA00, e_kill()));
        st.push_back(mk(0, 1, 32'h404, 6'b010000, 0, 0, 0, 32'h400, 32'hA00, e_trap(32'd6, 32'h400, 32'h400)));
        st.push_back(mk(0, 1, 32'h400, 6'b000000, 1, 0, 0, 32'h400, 32'hB00, e_kill()));
        st.push_back(mk(0, 1, 32'h404, 6'b010000, 0, 0, 0, 32'h400, 32'hA04, e_ret(32'hA04)));
        st.push_back(mk(0, 1, 32'hA04, 6'b000000, 0, 0, 0, 32'h400, 32'hA04, e_retire()));
        foreach (st[i]) begin
            apply(st[i]);
            #1;
            want = exp_q.pop_front();
            got  = observed();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h required %h", i, got, want);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; pc = 32'd0;
        exc_fetch_misalign = 1'b0; exc_illegal = 1'b0; exc_ebreak = 1'b0; exc_ecall = 1'b0;
        exc_load_misalign = 1'b0; exc_store_misalign = 1'b0;
        is_mret = 1'b0; irq_ext = 1'b0; mstatus_mie = 1'b0;
        mtvec_in = 32'd0; mepc_in = 32'd0;
        test_reset();
        test_illegal();
        test_mret();
        test_irq_priority();
        test_irq_masked();
        test_exc_priority();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

- Sequences every trap entry and MRET return for the RV32IM single-cycle core.
- Sits between decode/execute and the CSR file:
  - Collects synchronous exception flags, the MRET decode and the external interrupt line.
  - Picks the winning cause and kills the offending instruction.
  - Drives `trap_enter`/`trap_exit`, `exception_code` and `current_pc` into the CSR file.
  - Redirects the PC to `mtvec` or `mepc` over a two-cycle sequence.

## Interface
- Parameters:
  - `RESET_PC`, default `32'h0000_0000`: value of `redirect_pc` out of reset.
- Ports:
  - `clk`  in  1  system clock
  - `reset`  in  1  **synchronous, active-high reset**
  - `instr_valid`  in  1  instruction presented this cycle
  - `pc`  in  32  PC of presented instruction
  - `exc_fetch_misalign`, `exc_illegal`, `exc_ebreak`, `exc_ecall`, `exc_load_misalign`, `exc_store_misalign`  in  1 each  decode/execute exception flags
  - `is_mret`  in  1  presented instruction is MRET
  - `irq_ext`  in  1  level external interrupt, asynchronous to pipeline
  - `mstatus_mie`  in  1  mstatus.MIE from CSR file
  - `mtvec_in`  in  32  mtvec from CSR file
  - `mepc_in`  in  32  mepc from CSR file
  - `kill`  out  1  suppress register/memory/CSR writes of presented instruction
  - `stall`  out  1  hold PC; ignore presented instruction
  - `retire`  out  1  presented instruction completes normally
  - `trap_enter`  out  1  one-cycle pulse to CSR file
  - `trap_exit`  out  1  one-cycle pulse to CSR file
  - `exception_code`  out  32  mcause value
  - `current_pc`  out  32  mepc value to save
  - `redirect_valid`  out  1  PC must load `redirect_pc` at next edge
  - `redirect_pc`  out  32  redirect target

## Operation
- States: `S_RUN`, `S_TRAP`, `S_RET`. Reset state is `S_RUN`.
- Interrupt sampling:
  - `irq_q` <= `irq_ext` every cycle (single sync flop).
  - `irq_take` = `irq_q & mstatus_mie & instr_valid` in `S_RUN`.
- Cause priority in `S_RUN` (highest first), when `instr_valid`:
  - interrupt → `32'h8000_000B`
  - fetch misaligned → 0
  - illegal → 2
  - ebreak → 3
  - ecall → 11
  - load misaligned → 4
  - store misaligned → 6
- `S_RUN`, any cause present:
  - `kill`=1 combinationally.
  - Register cause into `cause_q` and `pc` into `epc_q`.
  - Next state `S_TRAP`.
  - On an interrupt, `epc_q` = `pc` of the unexecuted instruction.
- `S_RUN`, `is_mret` with no cause:
  - `kill`=1.
  - Next state `S_RET`.
  - An exception wins over MRET.
- `S_RUN`, otherwise:
  - `retire` = `instr_valid`.
- `S_TRAP`:
  - `trap_enter`=1, `exception_code`=`cause_q`, `current_pc`=`epc_q`.
  - `stall`=1, `redirect_valid`=1, `redirect_pc` = trap vector.
  - Next state `S_RUN`.
- `S_RET`:
  - `trap_exit`=1, `stall`=1, `redirect_valid`=1, `redirect_pc`=`mepc_in`.
  - Next state `S_RUN`.
- In `S_TRAP`/`S_RET`, `instr_valid`, exception flags and `irq_q` are ignored. No nested detection.
- `exception_code` and `current_pc` read 0 outside `S_TRAP`.
- Trap vector base is `{mtvec_in[31:2], 2'b00}`. Address arithmetic is 32-bit modulo 2^32, no overflow detection.

## Timing
- Trap entry latency, two cycles:
  - Detect cycle (kill).
  - `S_TRAP` cycle: CSR file captures mepc/mcause at the edge ending it; PC loads vector at the same edge.
- MRET latency, two cycles:
  - Detect cycle.
  - `S_RET` cycle: PC loads `mepc_in` at its end.
- `mepc_in` is read during `S_RET`, so a CSR write to mepc by the instruction preceding MRET is honoured.
- Interrupt visibility is one cycle after `irq_ext` rises. An `irq_ext` pulse shorter than one clock may be missed.
- Reset, checked before all else:
  - State `S_RUN`, `irq_q`/`cause_q`/`epc_q` = 0.
  - All outputs 0 except `redirect_pc` = `RESET_PC`.
  - Reset asserted in `S_TRAP`/`S_RET` aborts that sequence: no `trap_enter`/`trap_exit` pulse follows.

## Configuration
- Macro `TRAP_VECTORED_EN` defined:
  - If `mtvec_in[1:0]==2'b01` and the cause is an interrupt, vector = base + 4×`cause_q[4:0]`.
  - Synchronous exceptions always use base.
- Macro undefined:
  - `mtvec_in[1:0]` is ignored; every trap vectors to base.

## Test plan
- Illegal instruction at `pc=32'h100`, `mtvec_in=32'h200` → `kill`=1 at detect. Next cycle `trap_enter`=1, `exception_code`=2, `current_pc`=`32'h100`, `redirect_pc`=`32'h200`. Then `S_RUN`.
- MRET with `mepc_in=32'h104` → `kill`=1. Next cycle `trap_exit`=1, `redirect_valid`=1, `redirect_pc`=`32'h104`. `trap_enter` stays 0.
- `irq_ext`=1, `mstatus_mie`=1, `pc=32'h40`, `exc_ecall`=1 same cycle → interrupt wins: `exception_code`=`32'h8000_000B`, `current_pc`=`32'h40`. With `TRAP_VECTORED_EN` and `mtvec_in=32'h201`, `redirect_pc`=`32'h22C`; without the macro, `32'h200`.
- `irq_ext`=1 with `mstatus_mie`=0 for 10 cycles → no trap; `retire` follows `instr_valid`.
- `exc_load_misalign`=1 and `exc_store_misalign`=1 together → `exception_code`=4. `exc_ecall`+`is_mret` together → code 11, no `trap_exit`.
- Reset asserted during `S_TRAP` → next cycle all outputs 0, `redirect_pc`=`RESET_PC`, no `trap_enter` pulse.
